// File: rtl/mem_self_test.sv
// Self-test sequencer for the regfile and dmem targets: writes a seeded pattern, reads it
// back, compares, and reports pass/fail, mismatch count and first failing location.
module mem_self_test #(
    parameter int unsigned NUM_CHECK = 6,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic [31:0] reg_indata,
    input  logic [31:0] rv1,
    input  logic [31:0] rv2,
    output logic [31:0] dmem_daddr,
    output logic [1:0]  dmem_we,
    output logic [1:0]  dmem_r,
    output logic [31:0] dmem_indata,
    input  logic [31:0] dmem_outdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic        fail_phase,
    output logic [31:0] fail_addr
);

    typedef enum logic [2:0] {
        StIdle,
        StRegWr,
        StRegRd,
        StMemWr,
        StMemRd,
        StFin
    } state_e;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_inc;

    logic        mis_a;
    logic        mis_b;
    logic [1:0]  n_mis;
    logic [8:0]  err_sum;
    logic [7:0]  err_next;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] first_addr;

    function automatic logic [31:0] pattern(input logic [31:0] idx);
        return SEED + idx * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] mem_addr(input logic [31:0] idx);
        return MEM_BASE + (idx << 2);
    endfunction

    assign cnt_inc = cnt_q + 32'd1;

    // Compare the data returned for the locations presented during the cycle now ending.
    always_comb begin
        mis_a      = 1'b0;
        mis_b      = 1'b0;
        exp_a      = '0;
        exp_b      = '0;
        first_addr = '0;
        if (state_q == StRegRd) begin
            exp_a      = (rs1 == 5'd0) ? 32'h0 : pattern({27'h0, rs1});
            exp_b      = pattern({27'h0, rs2});
            mis_a      = (rv1 != exp_a);
            mis_b      = (rv2 != exp_b);
            first_addr = mis_a ? {27'h0, rs1} : {27'h0, rs2};
        end else if (state_q == StMemRd && cnt_q != 32'd0) begin
            exp_a      = pattern(cnt_q - 32'd1);
            mis_a      = (dmem_outdata != exp_a);
            first_addr = mem_addr(cnt_q - 32'd1);
        end
        n_mis    = {1'b0, mis_a} + {1'b0, mis_b};
        err_sum  = {1'b0, err_count} + {7'h0, n_mis};
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            reg_we      <= 1'b0;
            reg_indata  <= '0;
            dmem_daddr  <= '0;
            dmem_we     <= 2'b00;
            dmem_r      <= 2'b00;
            dmem_indata <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_phase  <= 1'b0;
            fail_addr   <= '0;
        end else begin
            done <= 1'b0;
            if (n_mis != 2'd0) begin
                err_count <= err_next;
                // A zero count means no mismatch has been seen yet in this pass.
                if (err_count == 8'd0) begin
                    fail_phase <= (state_q == StMemRd);
                    fail_addr  <= first_addr;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StRegWr;
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        reg_we     <= 1'b1;
                        rd         <= 5'd0;
                        reg_indata <= pattern(32'd0);
                        err_count  <= '0;
                        pass       <= 1'b0;
                        fail_phase <= 1'b0;
                        fail_addr  <= '0;
                    end
                end
                StRegWr: begin
                    if (cnt_q == 32'd31) begin
                        state_q <= StRegRd;
                        cnt_q   <= '0;
                        reg_we  <= 1'b0;
                        rs1     <= 5'd0;
                        rs2     <= 5'd1;
                    end else begin
                        cnt_q      <= cnt_inc;
                        rd         <= cnt_inc[4:0];
                        reg_indata <= pattern(cnt_inc);
                    end
                end
                StRegRd: begin
                    if (cnt_q == 32'd15) begin
                        state_q     <= StMemWr;
                        cnt_q       <= '0;
                        dmem_we     <= 2'b11;
                        dmem_daddr  <= MEM_BASE;
                        dmem_indata <= pattern(32'd0);
                    end else begin
                        cnt_q <= cnt_inc;
                        rs1   <= {cnt_inc[3:0], 1'b0};
                        rs2   <= {cnt_inc[3:0], 1'b1};
                    end
                end
                StMemWr: begin
                    if (cnt_q == NUM_CHECK - 1) begin
                        state_q    <= StMemRd;
                        cnt_q      <= '0;
                        dmem_we    <= 2'b00;
                        dmem_r     <= 2'b11;
                        dmem_daddr <= MEM_BASE;
                    end else begin
                        cnt_q       <= cnt_inc;
                        dmem_daddr  <= mem_addr(cnt_inc);
                        dmem_indata <= pattern(cnt_inc);
                    end
                end
                StMemRd: begin
                    // Issue of read i overlaps the compare of read i-1.
                    if (cnt_q == NUM_CHECK) begin
                        state_q <= StFin;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next == 8'd0);
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == NUM_CHECK) begin
                            dmem_r <= 2'b00;
                        end else begin
                            dmem_daddr <= mem_addr(cnt_inc);
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_self_test.md
# mem_self_test

Autonomous self-test initiator for the regfile and dmem test targets. It replaces manual VIO stimulus with a sequencer that drives the same write and read ports, collects the returned data and compares it against a generated pattern. It sits between the regfile/dmem instances and a small status interface that the VIO or ILA observes. One start pulse runs a full write, read-back and compare pass and reports pass/fail, an error count and the first failing location.

## Interface
Parameters:
- NUM_CHECK, 6: number of dmem words exercised.
- MEM_BASE, 32'h0000_0000: first dmem byte address; word i is at MEM_BASE + 4*i.
- SEED, 32'hA5A5_0000: pattern seed.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- rs1, rs2, rd  out  5 each  regfile read and write indices.
- reg_we  out  1  regfile write enable.
- reg_indata  out  32  regfile write data.
- rv1, rv2  in  32 each  regfile read data; combinational, valid in the same cycle.
- dmem_daddr  out  32  dmem byte address.
- dmem_we  out  2  2'b11 = word write, 2'b00 = idle.
- dmem_r  out  2  2'b11 = word read, 2'b00 = idle.
- dmem_indata  out  32  dmem write data.
- dmem_outdata  in  32  dmem read data; valid one cycle after the read is issued.
- busy  out  1  high while a test pass is running.
- done  out  1  one-cycle pulse when a pass ends.
- pass  out  1  result of the last pass; held until the next start is accepted.
- err_count  out  8  mismatches in the last pass; saturates at 255.
- fail_phase  out  1  phase of the first mismatch: 0 = regfile, 1 = dmem.
- fail_addr  out  32  location of the first mismatch: regfile index (zero-extended) or dmem byte address.

## Operation
- Pattern: P(i) = SEED + i*32'h0101_0101, computed modulo 2^32.
- The FSM runs IDLE -> REG_WR -> REG_RD -> MEM_WR -> MEM_RD -> FIN -> IDLE.
- IDLE: all strobes are 0. When start is seen, the block clears err_count, pass, fail_phase and fail_addr, and moves to REG_WR.
- REG_WR: 32 cycles, i = 0..31. rd = i, reg_indata = P(i), reg_we = 1.
  - The write to x0 is intentional; the block checks that x0 is hardwired.
- REG_RD: 16 cycles, k = 0..15. rs1 = 2k, rs2 = 2k+1, reg_we = 0.
  - rv1 is compared against E(2k) and rv2 against E(2k+1) in the same cycle.
  - E(0) = 0; E(i) = P(i) for i > 0.
- MEM_WR: NUM_CHECK cycles. dmem_daddr = MEM_BASE + 4i, dmem_indata = P(i), dmem_we = 2'b11.
- MEM_RD: NUM_CHECK + 1 cycles.
  - In cycles 0..NUM_CHECK-1, read i is issued: dmem_r = 2'b11, dmem_daddr = MEM_BASE + 4i.
  - In cycles 1..NUM_CHECK, dmem_outdata is compared against P(i-1). Issue and compare overlap (pipelined).
- FIN: one cycle. done = 1, busy = 0, pass = (err_count == 0).
- Error accounting:
  - err_count increases by the number of mismatches in the cycle: 0, 1 or 2 in REG_RD, and it saturates at 255.
  - fail_phase and fail_addr are captured only on the first mismatch of a pass.
  - If rv1 and rv2 both mismatch in the same cycle, the rs1 location is the one reported.
- Width rules: address and pattern arithmetic is 32-bit and wraps. Indices are 5-bit.
- start while busy or in FIN is ignored.

## Timing
- Reset (asynchronous, immediate): state = IDLE.
  - reg_we = 0, dmem_we = 2'b00, dmem_r = 2'b00.
  - All address and data outputs = 0.
  - busy = 0, done = 0, pass = 0, err_count = 0, fail_phase = 0, fail_addr = 0.
- Reset asserted mid-pass aborts the pass at once. No write strobe remains high after reset is asserted, and the aborted pass leaves no done pulse.
- If start is high at edge t, busy and the first REG_WR write appear after edge t.
- Run length: REG_WR + REG_RD + MEM_WR + MEM_RD = 32 + 16 + N + (N+1) cycles, which is 61 for N = 6. The FIN cycle (done) follows immediately.
- done is high for exactly 1 cycle. busy and done are never high together.
- All outputs are registered. Comparisons use inputs sampled at the rising edge.

## Test plan
- Ideal models (regfile with x0 hardwired, 1-cycle dmem), start pulse -> busy for 61 cycles, then done pulse; pass = 1, err_count = 0.
- Regfile model with x3 stuck at 0 -> pass = 0, err_count = 1, fail_phase = 0, fail_addr = 3. The expected value at x3 is P(3) = 32'hA8A8_0303.
- Regfile model where x0 stores its write -> err_count = 1, fail_addr = 0.
- dmem model that drops the write to word 5 (addr 0x14) -> err_count = 1, fail_phase = 1, fail_addr = 32'h14. The second pass, after restart, gives an identical result.
- Regfile returning all-ones -> err_count = 32, pass = 0, fail_addr = 0. Repeat with NUM_CHECK = 300 and a broken dmem -> err_count saturates at 255.
- Reset pulse in cycle 40 of a pass -> all strobes low immediately and no done pulse. A start 2 cycles after reset runs a full 61-cycle pass.
